// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encoding and a small operation decode helper.
package ex_muldiv_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } md_state_e;

   // Signed variants treat their operands as two's complement.
   function automatic logic md_op_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider core, one quotient bit per step, MSB first.
// Operands are unsigned; sign handling lives in the caller.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture dividend/divisor, clear partial remainder
//   step       : advance one iteration
//   dividend   : unsigned dividend (sampled on load)
//   divisor    : unsigned divisor, non-zero (sampled on load)
//   quotient   : quotient after the current step is applied
//   remainder  : remainder after the current step is applied
module ex_div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
   logic [WIDTH:0]   shifted, trial;

   // Shift the next dividend bit into the partial remainder and try a subtract.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dsr_q};

   // Outputs show the post-step value so the caller can commit on the final step.
   always_comb begin
      if (trial[WIDTH]) begin
         remainder = shifted[WIDTH-1:0];
         quotient  = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         remainder = trial[WIDTH-1:0];
         quotient  = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
      end else if (step) begin
         rem_q <= remainder;
         quo_q <= quotient;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   clk, rst     : clock, synchronous active-high reset
//   start        : EX stage presents a mul/div/mthi/mtlo instruction
//   op           : MD_OP_* operation code
//   src_a, src_b : rs / rt operands
//   flush        : exception flush, cancels any in-flight operation
//   stall        : combinational pipeline hold
//   done         : one-cycle pulse, HI/LO updated this cycle
//   div_by_zero  : set with done when a divide had a zero divisor
//   hi, lo       : HI and LO registers
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, product;
   logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               dbz_q, dbz_d;
   logic               div_load, div_step;
   logic [WIDTH-1:0]   quotient, remainder, abs_a, abs_b;
   logic               op_signed, a_neg, b_neg, b_zero, launch, is_mul, is_div;

   assign op_signed = md_op_signed(op);
   assign a_neg     = op_signed & src_a[WIDTH-1];
   assign b_neg     = op_signed & src_b[WIDTH-1];
   assign abs_a     = a_neg ? -src_a : src_a;
   assign abs_b     = b_neg ? -src_b : src_b;
   assign b_zero    = (src_b == '0);
   assign is_mul    = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   assign is_div    = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   assign launch    = (state_q == StIdle) && start && !flush;

   // Operands are pre-extended, so the low 2*WIDTH bits are correct for both signednesses.
   assign product = mul_a_q * mul_b_q;

   ex_div_iter #(
      .WIDTH (WIDTH)
   ) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (is_mul)                                      state_d = StMul;
                  else if (is_div)                                 state_d = b_zero ? StDone : StDiv;
                  else if (op == MD_OP_MTHI || op == MD_OP_MTLO)   state_d = StDone;
               end
            end
            StMul, StDiv: if (cnt_q == '0) state_d = StDone;
            StDone:       state_d = StIdle;
            default:      state_d = StIdle;
         endcase
      end
   end

   // Outputs; stall is held low during reset so the pipeline never waits on a dead unit.
   always_comb begin
      stall = !rst && ((state_q == StMul) || (state_q == StDiv) ||
                       (launch && (is_mul || (is_div && !b_zero))));
      done  = (state_q == StDone);
   end

   // Datapath next-state; nothing commits while a flush is present.
   always_comb begin
      cnt_d    = cnt_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      div_load = 1'b0;
      div_step = 1'b0;
      if (!flush) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (is_mul) begin
                     mul_a_d = {{WIDTH{a_neg}}, src_a};
                     mul_b_d = {{WIDTH{b_neg}}, src_b};
                     cnt_d   = CntW'(MUL_STAGES - 1);
                  end else if (is_div && b_zero) begin
                     hi_d  = src_a;
                     lo_d  = '1;
                     dbz_d = 1'b1;
                  end else if (is_div) begin
                     div_load = 1'b1;
                     q_neg_d  = a_neg ^ b_neg;
                     r_neg_d  = a_neg;
                     cnt_d    = CntW'(WIDTH - 1);
                  end else if (op == MD_OP_MTHI) begin
                     hi_d  = src_a;
                     dbz_d = 1'b0;
                  end else if (op == MD_OP_MTLO) begin
                     lo_d  = src_a;
                     dbz_d = 1'b0;
                  end
               end
            end
            StMul: begin
               if (cnt_q == '0) begin
                  {hi_d, lo_d} = product;
                  dbz_d        = 1'b0;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            StDiv: begin
               div_step = 1'b1;
               if (cnt_q == '0) begin
                  lo_d  = q_neg_q ? -quotient : quotient;
                  hi_d  = r_neg_q ? -remainder : remainder;
                  dbz_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized operations
// checked against an arithmetic reference model of HI/LO and latency.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned MS = 2;

   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b;
   logic         stall, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_hi, m_lo;
   logic        m_dbz;

   always #5 clk = ~clk;

   ex_muldiv #(
      .WIDTH      (W),
      .MUL_STAGES (MS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .flush       (flush),
      .stall       (stall),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
   task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic stalls);
      logic signed [63:0] sa, sb, sp;
      logic [63:0]        ua, ub, up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      lat    = 1;
      stalls = 1'b0;
      case (o)
         MD_OP_MULT, MD_OP_MULTU: begin
            up = (o == MD_OP_MULT) ? 64'(sa * sb) : ua * ub;
            m_hi = up[63:32];
            m_lo = up[31:0];
            m_dbz = 1'b0;
            lat = MS + 1;
            stalls = 1'b1;
         end
         MD_OP_DIV, MD_OP_DIVU: begin
            if (b == 32'b0) begin
               m_hi = a;
               m_lo = 32'hFFFF_FFFF;
               m_dbz = 1'b1;
            end else begin
               if (o == MD_OP_DIV) begin
                  sp = sa / sb;
                  m_lo = sp[31:0];
                  sp = sa % sb;
                  m_hi = sp[31:0];
               end else begin
                  up = ua / ub;
                  m_lo = up[31:0];
                  up = ua % ub;
                  m_hi = up[31:0];
               end
               m_dbz = 1'b0;
               lat = W + 1;
               stalls = 1'b1;
            end
         end
         MD_OP_MTHI: begin m_hi = a; m_dbz = 1'b0; end
         MD_OP_MTLO: begin m_lo = a; m_dbz = 1'b0; end
         default: ;
      endcase
   endtask

   // Issue one op, start held through DONE, checking stall/done every cycle.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int   lat;
      logic stalls;
      model_op(o, a, b, lat, stalls);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      for (int c = 0; c <= lat; c++) begin
         #1;
         check("stall", stall, (c < lat) && stalls);
         check("done", done, c == lat);
         if (c == lat) begin
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("dbz", div_by_zero, m_dbz);
         end
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      check("idle_after", {stall, done}, 2'b00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; flush = 1'b0; op = MD_OP_MULT;
      src_a = 32'hFFFF_FFFE; src_b = 32'd3;
      repeat (2) begin
         @(negedge clk);
         #1;
         check("rst_hi", hi, 0);
         check("rst_lo", lo, 0);
         check("rst_done", done, 0);
         check("rst_stall", stall, 0);
      end
      rst = 1'b0; start = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;

      do_op(MD_OP_MULT,  32'hFFFF_FFFE, 32'd3);
      do_op(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      do_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2);
      do_op(MD_OP_DIVU,  32'd100,       32'd7);
      do_op(MD_OP_DIVU,  32'd5,         32'd0);
      do_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      do_op(MD_OP_DIV,   32'd7,         32'hFFFF_FFFE);
      do_op(MD_OP_DIVU,  32'hFFFF_FFFF, 32'd1);

      // Flush a divide in cycle 10: no done, HI/LO untouched.
      @(negedge clk);
      start = 1'b1; op = MD_OP_DIV; src_a = 32'd1000; src_b = 32'd3;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("fl_stall", stall, 1);
         check("fl_done", done, 0);
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("fl_post", {stall, done}, 2'b00);
         check("fl_hi", hi, m_hi);
         check("fl_lo", lo, m_lo);
         @(negedge clk);
      end
      do_op(MD_OP_MULT, 32'd6, 32'd7);

      // Flush wins over start in IDLE.
      @(negedge clk);
      start = 1'b1; op = MD_OP_MULT; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
      #1;
      check("prio_stall", stall, 0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("prio_post", {stall, done}, 2'b00);
      check("prio_lo", lo, m_lo);

      // Undefined op is ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF; src_b = 32'd1;
      #1;
      check("undef_stall", stall, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("undef_done", done, 0);
      check("undef_hi", hi, m_hi);
      check("undef_lo", lo, m_lo);

      do_op(MD_OP_MTHI, 32'h1234, 32'd0);
      do_op(MD_OP_MTLO, 32'h5678, 32'd0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         if ($urandom_range(0, 7) == 0)      rb = 32'd0;
         else if ($urandom_range(0, 1) == 1) rb = $urandom;
         else                                rb = 32'($urandom_range(1, 20));
         do_op(ro, ra, rb);
      end

      // Reset mid-multiply after a divide-by-zero left div_by_zero set.
      do_op(MD_OP_DIV, 32'd77, 32'd0);
      @(negedge clk);
      start = 1'b1; op = MD_OP_MULTU; src_a = 32'd3; src_b = 32'd4;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      #1;
      check("mr_hi", hi, 0);
      check("mr_lo", lo, 0);
      check("mr_dbz", div_by_zero, 0);
      check("mr_sd", {stall, done}, 2'b00);
      @(negedge clk);
      #1;
      check("mr_post", {stall, done}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
